priority_frame_decoder3to8: RTL and testbench
=============================================

// Module: priority_frame_decoder3to8
// PURPOSE
//  Inverse of the 8-to-3 priority encoder. Accepts a stream of 3-bit encoded
//  indices, grouped into frames, over a valid/ready handshake.
//  Emits a registered one-hot decode for every accepted beat.
//  Rebuilds the full request vector for each frame and checks that the beats
//  arrived in strict priority order (highest index first, as the encoder grants).
//  Sits downstream of the encoder to reconstruct and audit request masks.
// PARAMETERS
//  IDX_W   3               encoded index width
//  OUT_W   (1<<IDX_W) = 8  one-hot / mask width; must equal 1<<IDX_W
//  CNT_W   IDX_W+1 = 4     beat counter width
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      encoded beat valid
//  in_ready     out  1      block can accept a beat
//  in_idx       in   IDX_W  encoded index
//  in_last      in   1      beat is last of frame
//  dec_valid    out  1      dec_onehot valid (one cycle per accepted beat)
//  dec_onehot   out  OUT_W  1<<in_idx of accepted beat
//  frame_valid  out  1      one-cycle pulse: frame result valid
//  frame_mask   out  OUT_W  OR of all one-hots in frame
//  frame_count  out  CNT_W  beats in frame, saturating at 2^CNT_W-1
//  order_err    out  1      frame violated strict descending order
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE. All outputs are 0, including in_ready.
//    Accumulators and the previous-index register clear. A partial frame is discarded.
//  - Transfer = in_valid & in_ready, sampled on posedge clk.
//  - FSM:
//    - IDLE: transfer & !last -> COLLECT; transfer & last -> DONE.
//    - COLLECT: transfer & last -> DONE; otherwise stay.
//    - DONE: lasts exactly 1 cycle, then -> IDLE unconditionally.
//  - in_ready is a function of state only: 1 in IDLE/COLLECT, 0 in DONE.
//    This gives exactly one bubble per frame.
//  - Decode path (latency 1):
//    - Cycle after a transfer: dec_valid=1, dec_onehot=1<<in_idx.
//    - Otherwise: dec_valid=0, dec_onehot=0.
//  - Accumulation:
//    - First beat of a frame (transfer in IDLE) loads acc_mask=onehot, acc_cnt=1,
//      err=0, prev=idx.
//    - Later beats: acc_mask |= onehot; acc_cnt+1 (saturating);
//      err |= (idx >= prev); prev=idx.
//  - Frame result: in the DONE cycle (one cycle after the last-beat transfer),
//    frame_valid=1 and frame_mask/frame_count/order_err present the final frame
//    values, including the last beat.
//    - frame_mask, frame_count and order_err hold until the next frame_valid.
//    - frame_valid is 0 in all other cycles.
//  - Duplicate index is an order error: mask bit is unchanged, count still increments.
//  - A single-beat frame never flags order_err.
//  - in_idx/in_last are ignored when there is no transfer (in_valid=0 or in DONE).
//  - in_valid held high during DONE: beat is not accepted; it is accepted in the next
//    (IDLE) cycle as the first beat of a new frame.
// TESTING
//  1. Frame {4,last} -> next cycle dec_onehot=00010000; DONE cycle frame_mask=00010000,
//     frame_count=1, order_err=0.
//  2. Back-to-back {7,6,5,4,last} -> dec_onehot 10000000..00010000 on consecutive
//     cycles; frame_mask=11110000, frame_count=4, order_err=0.
//  3. {6,2,last} with in_valid gaps, then in_valid held high -> frame_mask=01000100,
//     count=2; in_ready=0 exactly in the DONE cycle; next beat accepted one cycle later.
//  4. {2,5,last} -> frame_mask=00100100, order_err=1; following {0,last} ->
//     frame_mask=00000001, order_err=0.
//  5. {3,3,last} -> frame_mask=00001000, frame_count=2, order_err=1.
//     {7..0 all 8 beats} -> frame_mask=11111111, count=8, err=0.
//  6. Reset asserted mid-frame after {7,6} -> all outputs 0 immediately (async);
//     after release, {1,last} -> frame_mask=00000010, count=1, no leftover bits.

Source files
------------

// File: rtl/priority_frame_decoder3to8.sv
// Decodes a stream of encoded indices into one-hot beats and rebuilds each frame's
// request mask, beat count and strict-descending-order check.
module priority_frame_decoder3to8 #(
  parameter int IDX_W = 3,
  parameter int OUT_W = 1 << IDX_W,
  parameter int CNT_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic             dec_valid,
  output logic [OUT_W-1:0] dec_onehot,
  output logic             frame_valid,
  output logic [OUT_W-1:0] frame_mask,
  output logic [CNT_W-1:0] frame_count,
  output logic             order_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [OUT_W-1:0]   onehot;
  logic               transfer;
  logic               first_beat;
  logic [OUT_W-1:0]   acc_mask_reg, acc_mask_next;
  logic [CNT_W-1:0]   acc_cnt_reg, acc_cnt_next;
  logic               acc_err_reg, acc_err_next;
  logic [IDX_W-1:0]   prev_idx_reg;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_onehot
      assign onehot[gi] = (in_idx == IDX_W'(gi));
    end
  endgenerate

  // Gating with rst_n keeps in_ready low while reset is held, not just after it.
  assign in_ready    = rst_n & (state_reg != DONE);
  assign transfer    = in_valid & in_ready;
  assign first_beat  = (state_reg == IDLE);
  assign frame_valid = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (transfer) state_next = in_last ? DONE : COLLECT;
      COLLECT: if (transfer && in_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_mask_next = acc_mask_reg | onehot;
    acc_cnt_next  = (acc_cnt_reg == CNT_MAX) ? acc_cnt_reg : acc_cnt_reg + CNT_ONE;
    acc_err_next  = acc_err_reg | (in_idx >= prev_idx_reg);
    if (first_beat) begin
      acc_mask_next = onehot;
      acc_cnt_next  = CNT_ONE;
      acc_err_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      dec_valid    <= 1'b0;
      dec_onehot   <= '0;
      acc_mask_reg <= '0;
      acc_cnt_reg  <= '0;
      acc_err_reg  <= 1'b0;
      prev_idx_reg <= '0;
      frame_mask   <= '0;
      frame_count  <= '0;
      order_err    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dec_valid  <= transfer;
      dec_onehot <= transfer ? onehot : '0;
      if (transfer) begin
        acc_mask_reg <= acc_mask_next;
        acc_cnt_reg  <= acc_cnt_next;
        acc_err_reg  <= acc_err_next;
        prev_idx_reg <= in_idx;
        // Publish on the last beat so the result appears in the DONE cycle.
        if (in_last) begin
          frame_mask  <= acc_mask_next;
          frame_count <= acc_cnt_next;
          order_err   <= acc_err_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_priority_frame_decoder3to8.sv
// Table-driven frame vectors plus hand sequences for handshake gaps, DONE bubble and reset.
module tb_priority_frame_decoder3to8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_idx;
  logic       in_last;
  logic       dec_valid;
  logic [7:0] dec_onehot;
  logic       frame_valid;
  logic [7:0] frame_mask;
  logic [3:0] frame_count;
  logic       order_err;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  priority_frame_decoder3to8 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_last(in_last),
    .dec_valid(dec_valid), .dec_onehot(dec_onehot),
    .frame_valid(frame_valid), .frame_mask(frame_mask),
    .frame_count(frame_count), .order_err(order_err)
  );

  typedef struct {
    int               n;
    logic [16:0][2:0] idx;
    logic [7:0]       mask;
    logic [3:0]       cnt;
    logic             err;
  } frame_vec_t;

  frame_vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] one;
    one = 8'd1;
    return one << i;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " in_ready"},    32'(in_ready), 0);
    chk({tag, " dec_valid"},   32'(dec_valid), 0);
    chk({tag, " dec_onehot"},  32'(dec_onehot), 0);
    chk({tag, " frame_valid"}, 32'(frame_valid), 0);
    chk({tag, " frame_mask"},  32'(frame_mask), 0);
    chk({tag, " frame_count"}, 32'(frame_count), 0);
    chk({tag, " order_err"},   32'(order_err), 0);
  endtask

  // Back-to-back beats driven at negedge; checks decode, DONE result and hold.
  task automatic send_frame(input int k, input frame_vec_t v);
    for (int j = 0; j < v.n; j++) begin
      @(negedge clk);
      if (j > 0) begin
        chk($sformatf("v%0d dec_valid b%0d", k, j - 1), 32'(dec_valid), 1);
        chk($sformatf("v%0d dec_onehot b%0d", k, j - 1), 32'(dec_onehot), 32'(oh(v.idx[j-1])));
        chk($sformatf("v%0d frame_valid b%0d", k, j - 1), 32'(frame_valid), 0);
      end
      chk($sformatf("v%0d in_ready b%0d", k, j), 32'(in_ready), 1);
      in_valid = 1'b1;
      in_idx   = v.idx[j];
      in_last  = (j == v.n - 1);
    end
    @(negedge clk);
    chk($sformatf("v%0d dec_onehot last", k), 32'(dec_onehot), 32'(oh(v.idx[v.n-1])));
    chk($sformatf("v%0d frame_valid", k), 32'(frame_valid), 1);
    chk($sformatf("v%0d in_ready done", k), 32'(in_ready), 0);
    chk($sformatf("v%0d frame_mask", k), 32'(frame_mask), 32'(v.mask));
    chk($sformatf("v%0d frame_count", k), 32'(frame_count), 32'(v.cnt));
    chk($sformatf("v%0d order_err", k), 32'(order_err), 32'(v.err));
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d frame_valid after", k), 32'(frame_valid), 0);
    chk($sformatf("v%0d dec_valid after", k), 32'(dec_valid), 0);
    chk($sformatf("v%0d frame_mask hold", k), 32'(frame_mask), 32'(v.mask));
    chk($sformatf("v%0d frame_count hold", k), 32'(frame_count), 32'(v.cnt));
    $display("[TB] frame v%0d beats=%0d mask=%b count=%0d err=%0b", k, v.n, frame_mask,
             frame_count, order_err);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vecs[i].idx = '0;
    vecs[0].n = 1; vecs[0].idx[0] = 3'd4;
    vecs[0].mask = 8'b0001_0000; vecs[0].cnt = 4'd1; vecs[0].err = 1'b0;
    vecs[1].n = 4;
    vecs[1].idx[0] = 3'd7; vecs[1].idx[1] = 3'd6; vecs[1].idx[2] = 3'd5; vecs[1].idx[3] = 3'd4;
    vecs[1].mask = 8'b1111_0000; vecs[1].cnt = 4'd4; vecs[1].err = 1'b0;
    vecs[2].n = 2; vecs[2].idx[0] = 3'd2; vecs[2].idx[1] = 3'd5;
    vecs[2].mask = 8'b0010_0100; vecs[2].cnt = 4'd2; vecs[2].err = 1'b1;
    vecs[3].n = 1; vecs[3].idx[0] = 3'd0;
    vecs[3].mask = 8'b0000_0001; vecs[3].cnt = 4'd1; vecs[3].err = 1'b0;
    vecs[4].n = 2; vecs[4].idx[0] = 3'd3; vecs[4].idx[1] = 3'd3;
    vecs[4].mask = 8'b0000_1000; vecs[4].cnt = 4'd2; vecs[4].err = 1'b1;
    vecs[5].n = 8;
    for (int j = 0; j < 8; j++) vecs[5].idx[j] = 3'(7 - j);
    vecs[5].mask = 8'b1111_1111; vecs[5].cnt = 4'd8; vecs[5].err = 1'b0;
    vecs[6].n = 3; vecs[6].idx[0] = 3'd5; vecs[6].idx[1] = 3'd7; vecs[6].idx[2] = 3'd1;
    vecs[6].mask = 8'b1010_0010; vecs[6].cnt = 4'd3; vecs[6].err = 1'b1;
    // 17 beats: count saturates at 15; restart at 7 after 0 is an order error.
    vecs[7].n = 17;
    for (int j = 0; j < 16; j++) vecs[7].idx[j] = 3'(7 - (j % 8));
    vecs[7].idx[16] = 3'd3;
    vecs[7].mask = 8'b1111_1111; vecs[7].cnt = 4'd15; vecs[7].err = 1'b1;

    rst_n = 1'b0; in_valid = 1'b0; in_idx = 3'd0; in_last = 1'b0;
    #1;
    chk_all_zero("reset");
    $display("[TB] reset held: in_ready=%0b dec_valid=%0b frame_valid=%0b", in_ready, dec_valid,
             frame_valid);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 32'(in_ready), 1);
    chk("post-reset frame_valid", 32'(frame_valid), 0);

    for (int k = 0; k < 8; k++) send_frame(k, vecs[k]);

    // {6, gap, gap, 2 last} then valid held through the DONE bubble.
    @(negedge clk);
    in_valid = 1'b1; in_idx = 3'd6; in_last = 1'b0;
    @(negedge clk);
    chk("gap dec 6", 32'(dec_onehot), 32'h40);
    in_valid = 1'b0; in_idx = 3'd1; in_last = 1'b1;
    @(negedge clk);
    chk("gap idle dec_valid", 32'(dec_valid), 0);
    chk("gap in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b1; in_idx = 3'd2; in_last = 1'b1;
    @(negedge clk);
    chk("gap dec 2", 32'(dec_onehot), 32'h04);
    chk("gap frame_valid", 32'(frame_valid), 1);
    chk("gap frame_mask", 32'(frame_mask), 32'b0100_0100);
    chk("gap frame_count", 32'(frame_count), 2);
    chk("gap order_err", 32'(order_err), 0);
    chk("gap in_ready done", 32'(in_ready), 0);
    in_idx = 3'd5; in_last = 1'b1;
    @(negedge clk);
    chk("held dec_valid (not accepted in DONE)", 32'(dec_valid), 0);
    chk("held in_ready idle", 32'(in_ready), 1);
    chk("held frame_valid", 32'(frame_valid), 0);
    @(negedge clk);
    chk("held dec_valid", 32'(dec_valid), 1);
    chk("held dec_onehot", 32'(dec_onehot), 32'h20);
    chk("held frame_valid", 32'(frame_valid), 1);
    chk("held frame_mask", 32'(frame_mask), 32'h20);
    chk("held frame_count", 32'(frame_count), 1);
    in_valid = 1'b0;
    $display("[TB] gap/held sequence mask=%b count=%0d", frame_mask, frame_count);

    // Reset mid-frame after {7,6}.
    @(negedge clk);
    in_valid = 1'b1; in_idx = 3'd7; in_last = 1'b0;
    @(negedge clk);
    in_idx = 3'd6;
    @(posedge clk);
    #2;
    chk("midframe dec_valid before reset", 32'(dec_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset release in_ready", 32'(in_ready), 1);
    $display("[TB] mid-frame reset applied and released");
    vecs[0].idx[0] = 3'd1; vecs[0].n = 1;
    vecs[0].mask = 8'b0000_0010; vecs[0].cnt = 4'd1; vecs[0].err = 1'b0;
    send_frame(8, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
